// File: rtl/elevator_pkg.sv
// Shared constants for the elevator car controller: FSM state codes and direction encoding.
package elevator_pkg;

    localparam int FLOOR_W = 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MOVE   = 2'd1;
    localparam logic [1:0] ST_ARRIVE = 2'd2;
    localparam logic [1:0] ST_DOOR   = 2'd3;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/lift_timer.sv
// Down-counter shared by travel and door phases; reloads on load, otherwise counts to zero and holds.
module lift_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    output logic               expired
);
    import elevator_pkg::*;

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - TIMER_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/elevator_car_controller.sv
// Car-side sequencer: moves one floor per travel interval, owns the door, and reports floor,
// direction and arrival back to the request manager.
module elevator_car_controller #(
    parameter int NUM_FLOORS    = 4,
    parameter int FLOOR_W       = 2,
    parameter int TRAVEL_CYCLES = 100,
    parameter int DOOR_CYCLES   = 200,
    parameter int TIMER_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ud_request,
    input  logic               oc_request,
    input  logic               stop_pending,
    input  logic               door_hold,
    output logic [FLOOR_W-1:0] current_floor,
    output logic               dir,
    output logic               arrive,
    output logic               motor_up,
    output logic               motor_down,
    output logic               door_open,
    output logic               illegal_cmd
);
    import elevator_pkg::*;

    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [FLOOR_W-1:0] floor_d;
    logic               dir_d;
    logic               illegal_d;
    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_value;
    logic               tmr_expired;

    lift_timer #(
        .TIMER_W(TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (tmr_load),
        .load_value (tmr_value),
        .expired    (tmr_expired)
    );

    // Manager handshake: IDLE and ARRIVE are decision cycles. The manager drives oc_request,
    // stop_pending and ud_request combinationally during them; they are sampled at cycle end,
    // door before move. In MOVE and DOOR those commands are ignored.
    always_comb begin
        state_d   = state_q;
        floor_d   = current_floor;
        dir_d     = dir;
        illegal_d = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = TRAVEL_LOAD;
        case (state_q)
            ST_IDLE, ST_ARRIVE: begin
                state_d = ST_IDLE;
                if (oc_request) begin
                    state_d   = ST_DOOR;
                    tmr_load  = 1'b1;
                    tmr_value = DOOR_LOAD;
                end else if (stop_pending) begin
                    dir_d = ud_request;
                    if ((ud_request == DIR_UP) ? (current_floor == TOP_FLOOR)
                                               : (current_floor == '0)) begin
                        illegal_d = 1'b1;
                    end else begin
                        state_d  = ST_MOVE;
                        tmr_load = 1'b1;
                    end
                end
            end
            ST_MOVE: begin
                if (tmr_expired) begin
                    floor_d = (dir == DIR_UP) ? current_floor + FLOOR_W'(1)
                                              : current_floor - FLOOR_W'(1);
                    state_d = ST_ARRIVE;
                end
            end
            ST_DOOR: begin
                if (door_hold) begin
                    tmr_load  = 1'b1;
                    tmr_value = DOOR_LOAD;
                end else if (tmr_expired) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            current_floor <= '0;
            dir           <= DIR_UP;
            arrive        <= 1'b0;
            motor_up      <= 1'b0;
            motor_down    <= 1'b0;
            door_open     <= 1'b0;
            illegal_cmd   <= 1'b0;
        end else begin
            state_q       <= state_d;
            current_floor <= floor_d;
            dir           <= dir_d;
            arrive        <= (state_d == ST_ARRIVE);
            motor_up      <= (state_d == ST_MOVE) && (dir_d == DIR_UP);
            motor_down    <= (state_d == ST_MOVE) && (dir_d == DIR_DOWN);
            door_open     <= (state_d == ST_DOOR);
            illegal_cmd   <= illegal_d;
        end
    end

endmodule

// File: tb/tb_elevator_car_controller.sv
// Bench for elevator_car_controller: directed trips plus random trips checked against a
// trip-level model of floor, direction and per-cycle output pattern.
module tb_elevator_car_controller;

    localparam int NF     = 4;
    localparam int FW     = 2;
    localparam int TRAVEL = 4;
    localparam int DOOR   = 3;

    logic          clk;
    logic          rst_n;
    logic          ud_request;
    logic          oc_request;
    logic          stop_pending;
    logic          door_hold;
    logic [FW-1:0] current_floor;
    logic          dir;
    logic          arrive;
    logic          motor_up;
    logic          motor_down;
    logic          door_open;
    logic          illegal_cmd;

    elevator_car_controller #(
        .NUM_FLOORS    (NF),
        .FLOOR_W       (FW),
        .TRAVEL_CYCLES (TRAVEL),
        .DOOR_CYCLES   (DOOR),
        .TIMER_W       (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ud_request    (ud_request),
        .oc_request    (oc_request),
        .stop_pending  (stop_pending),
        .door_hold     (door_hold),
        .current_floor (current_floor),
        .dir           (dir),
        .arrive        (arrive),
        .motor_up      (motor_up),
        .motor_down    (motor_down),
        .door_open     (door_open),
        .illegal_cmd   (illegal_cmd)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         m_floor  = 0;
    logic       m_dir    = 1'b1;
    logic [7:0] exp_q[$];

    function automatic logic [7:0] pack(input int fl, input logic d, input logic arr,
                                        input logic mu, input logic md, input logic dr,
                                        input logic ill);
        logic [FW-1:0] f;
        f = FW'(fl);
        return {f, d, arr, mu, md, dr, ill};
    endfunction

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %b expected %b (floor,dir,arr,up,dn,door,ill) t=%0t",
                      tag, obs, exp_v, $time);
    endtask

    // scoreboard: compare one cycle of outputs against the oldest queued expectation
    task automatic observe(input string tag);
        logic [7:0] e;
        @(negedge clk);
        e = exp_q.pop_front();
        check_eq(tag, {current_floor, dir, arrive, motor_up, motor_down, door_open, illegal_cmd}, e);
    endtask

    task automatic idle_expect(input string tag);
        exp_q.push_back(pack(m_floor, m_dir, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        observe(tag);
    endtask

    // driver tasks: each begins at a decision cycle (IDLE or ARRIVE) and ends at one
    task automatic do_idle();
        stop_pending = 1'b0; oc_request = 1'b0; door_hold = 1'b0;
        ud_request   = 1'($urandom_range(1, 0));
        idle_expect("idle");
    endtask

    task automatic do_move(input logic up);
        stop_pending = 1'b1; ud_request = up; oc_request = 1'b0; door_hold = 1'b0;
        m_dir = up;
        if ((up && m_floor == NF - 1) || (!up && m_floor == 0)) begin
            exp_q.push_back(pack(m_floor, m_dir, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
            observe("illegal_strobe");
            stop_pending = 1'b0;
            idle_expect("after_illegal");
        end else begin
            for (int i = 0; i < TRAVEL; i++) begin
                exp_q.push_back(pack(m_floor, m_dir, 1'b0, up, !up, 1'b0, 1'b0));
                observe("moving");
                ud_request   = 1'($urandom_range(1, 0));
                stop_pending = 1'($urandom_range(1, 0));
                oc_request   = 1'($urandom_range(1, 0));
                door_hold    = 1'($urandom_range(1, 0));
            end
            m_floor = up ? m_floor + 1 : m_floor - 1;
            exp_q.push_back(pack(m_floor, m_dir, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
            observe("arrive");
            stop_pending = 1'b0; oc_request = 1'b0; door_hold = 1'b0;
        end
    endtask

    task automatic do_door(input int hold_n);
        oc_request   = 1'b1;
        stop_pending = 1'($urandom_range(1, 0));
        ud_request   = 1'($urandom_range(1, 0));
        door_hold    = 1'b0;
        for (int k = 1; k <= hold_n + DOOR; k++) begin
            exp_q.push_back(pack(m_floor, m_dir, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
            observe("door_open");
            oc_request   = 1'($urandom_range(1, 0));
            stop_pending = 1'($urandom_range(1, 0));
            ud_request   = 1'($urandom_range(1, 0));
            door_hold    = (k <= hold_n);
        end
        idle_expect("door_closed");
        oc_request = 1'b0; stop_pending = 1'b0; door_hold = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ud_request = 1'b0; oc_request = 1'b0; stop_pending = 1'b0; door_hold = 1'b0;
        #12;
        check_eq("reset_state", {current_floor, dir, arrive, motor_up, motor_down, door_open,
                 illegal_cmd}, pack(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        do_move(1'b1);      // up one floor
        do_door(0);         // door answered during arrive
        do_move(1'b1);
        do_move(1'b1);
        do_idle();
        do_move(1'b1);      // past top floor
        do_door(5);         // hold extends door time
        do_move(1'b0);      // run down to floor 0 with stop held
        do_move(1'b0);
        do_move(1'b0);
        do_move(1'b0);      // past bottom floor

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(4, 0))
                0, 1, 2: do_move(1'($urandom_range(1, 0)));
                3:       do_door(int'($urandom_range(4, 0)));
                default: do_idle();
            endcase
        end

        while (m_floor < 2) do_move(1'b1);
        while (m_floor > 2) do_move(1'b0);
        stop_pending = 1'b1; ud_request = 1'b1; oc_request = 1'b0; door_hold = 1'b0;
        m_dir = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(pack(m_floor, m_dir, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
            observe("moving_before_reset");
        end
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_reset_mid_move", {current_floor, dir, arrive, motor_up, motor_down,
                 door_open, illegal_cmd}, pack(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        stop_pending = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        m_floor = 0;
        m_dir   = 1'b1;
        do_idle();

        for (int n = 0; n < 20; n++) begin
            case ($urandom_range(2, 0))
                0:       do_move(1'($urandom_range(1, 0)));
                1:       do_door(int'($urandom_range(2, 0)));
                default: do_idle();
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
